// File: rtl/uart_dump_pkg.sv
// Shared definitions for the UART hex dump read-back path.
// Contents:
//   state_t       - dump controller states
//   ASCII_*       - character constants used in the output stream
//   hex_to_ascii  - maps a 4-bit nibble to its uppercase ASCII hex digit
package uart_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_GAP     = 3'd4,
        ST_WAIT    = 3'd5,
        ST_NEXT    = 3'd6
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    // Uppercase only, so the output can be fed straight back into the loader.
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return ASCII_0 + {4'd0, nibble};
        end
        return ASCII_A + {4'd0, nibble} - 8'd10;
    endfunction

endpackage

// File: rtl/hex_char_sel.sv
// Combinational selector for the character currently being transmitted.
// Ports:
//   word     in  WORD_W  captured memory word
//   char_idx in  IDX_W   character position within the word's output sequence
//   char_out out 8       ASCII byte for that position
// Positions 0..WORD_W/4-1 are hex digits, most significant nibble first;
// when SEP_EN is set, the next two positions are CR and LF.
module hex_char_sel
    import uart_dump_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int SEP_EN = 1,
    parameter int IDX_W  = 4
) (
    input  logic [WORD_W-1:0] word,
    input  logic [IDX_W-1:0]  char_idx,
    output logic [7:0]        char_out
);

    localparam int NIB = WORD_W / 4;

    always_comb begin
        char_out = 8'h00;
        for (int i = 0; i < NIB; i++) begin
            if (char_idx == IDX_W'(i)) begin
                char_out = hex_to_ascii(word[WORD_W-1-4*i -: 4]);
            end
        end
        if (SEP_EN != 0) begin
            if (char_idx == IDX_W'(NIB)) begin
                char_out = ASCII_CR;
            end
            if (char_idx == IDX_W'(NIB + 1)) begin
                char_out = ASCII_LF;
            end
        end
    end

endmodule

// File: rtl/uart_hex_dump.sv
// Reads COUNT consecutive words from a synchronous-read memory starting at
// BASE and streams each one to the uart transmitter as uppercase ASCII hex,
// optionally followed by CR LF.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle dump request (only honoured when idle)
//   base_addr, count    first address and word count, captured on start
//   mem_rd_en, mem_addr memory read request; mem_rdata valid one cycle later
//   tx_din, tx_wr_en    byte and write strobe to the uart transmitter
//   tx_busy             uart transmitter busy
//   busy                controller is not idle
//   done                one-cycle pulse when a dump (including count=0) ends
module uart_hex_dump
    import uart_dump_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 4,
    parameter int SEP_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [7:0]        tx_din,
    output logic              tx_wr_en,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done
);

    localparam int NIB   = WORD_W / 4;
    localparam int NCHAR = NIB + ((SEP_EN != 0) ? 2 : 0);
    localparam int IDX_W = $clog2(NCHAR + 1);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHAR - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  rem_q;
    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  idx_q;
    logic [7:0]        din_q;
    logic              done_q;
    logic [7:0]        char_cur;

    hex_char_sel #(
        .WORD_W (WORD_W),
        .SEP_EN (SEP_EN),
        .IDX_W  (IDX_W)
    ) u_char_sel (
        .word     (word_q),
        .char_idx (idx_q),
        .char_out (char_cur)
    );

    always_comb begin
        state_n   = state;
        mem_rd_en = 1'b0;
        tx_wr_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && count != '0) begin
                    state_n = ST_READ;
                end
            end
            ST_READ: begin
                mem_rd_en = 1'b1;
                state_n   = ST_CAPTURE;
            end
            ST_CAPTURE: state_n = ST_SEND;
            ST_SEND: begin
                if (!tx_busy) begin
                    tx_wr_en = 1'b1;
                    state_n  = ST_GAP;
                end
            end
            // The uart raises tx_busy one cycle after wr_en; skip that cycle.
            ST_GAP: state_n = ST_WAIT;
            ST_WAIT: begin
                if (!tx_busy) begin
                    state_n = (idx_q == LAST_IDX) ? ST_NEXT : ST_SEND;
                end
            end
            ST_NEXT: state_n = (rem_q == CNT_W'(1)) ? ST_IDLE : ST_READ;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            addr_q <= '0;
            rem_q  <= '0;
            word_q <= '0;
            idx_q  <= '0;
            din_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            addr_q <= base_addr;
                            rem_q  <= count;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_CAPTURE: begin
                    word_q <= mem_rdata;
                    idx_q  <= '0;
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        din_q <= char_cur;
                    end
                end
                ST_WAIT: begin
                    if (!tx_busy && idx_q != LAST_IDX) begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_NEXT: begin
                    rem_q  <= rem_q - CNT_W'(1);
                    addr_q <= addr_q + ADDR_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Present the new character in the write cycle itself; hold it afterwards.
    assign tx_din   = tx_wr_en ? char_cur : din_q;
    assign mem_addr = addr_q;
    assign busy     = (state != ST_IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_uart_hex_dump.sv
module tb_uart_hex_dump;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 4;
    localparam int SEP_EN = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   count = '0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_rdata;
    logic [7:0]        tx_din;
    logic              tx_wr_en;
    logic              tx_busy;
    logic              busy;
    logic              done;

    uart_hex_dump #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W),
        .SEP_EN (SEP_EN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .tx_din    (tx_din),
        .tx_wr_en  (tx_wr_en),
        .tx_busy   (tx_busy),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Memory model: synchronous read, garbage on the bus when not reading.
    logic [WORD_W-1:0] mem [16];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        else           mem_rdata <= $urandom();
    end

    // Uart model: busy rises the cycle after a write and lasts busy_len cycles.
    int busy_cnt  = 0;
    int busy_len  = 10;
    bit rand_busy = 1'b0;
    bit hold_busy = 1'b0;
    always @(posedge clk) begin
        if (tx_wr_en)          busy_cnt <= rand_busy ? int'($urandom_range(0, 4)) : busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0) || hold_busy;

    // Scoreboard state
    logic [7:0]        exp_bytes[$];
    logic [ADDR_W-1:0] exp_addrs[$];
    logic [7:0]        got_bytes[$];
    int  exp_done = 0;
    int  done_seen = 0;
    int  cyc = 0;
    int  start_cyc = 0;
    int  last_wr_cyc = 0;
    bit  chk_first_rd = 0, chk_first_wr = 0, chk_done_cyc = 0;
    bit  prev_wr = 0, prev_done = 0;
    logic [7:0] last_din = 8'h00;
    int  n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic void push_word(input logic [31:0] w);
        for (int i = 0; i < 8; i++) begin
            int n;
            n = int'((w >> (28 - 4 * i)) & 32'hF);
            exp_bytes.push_back((n < 10) ? 8'(8'h30 + n) : 8'(8'h41 + n - 10));
        end
        if (SEP_EN != 0) begin
            exp_bytes.push_back(8'h0D);
            exp_bytes.push_back(8'h0A);
        end
    endfunction

    // Per-cycle compare process
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_wr   = 0;
                prev_done = 0;
                last_din  = 8'h00;
            end else begin
                if (tx_wr_en) begin
                    chk("wr_while_busy", tx_busy, 0);
                    chk("wr_back_to_back", prev_wr, 0);
                    chk("busy_during_wr", busy, 1);
                    chk("byte_expected", exp_bytes.size() != 0, 1);
                    if (exp_bytes.size() != 0) chk("tx_byte", tx_din, exp_bytes.pop_front());
                    if (chk_first_wr) begin
                        chk("first_wr_latency", cyc - start_cyc, 3);
                        chk_first_wr = 0;
                    end
                    got_bytes.push_back(tx_din);
                    last_din    = tx_din;
                    last_wr_cyc = cyc;
                end else begin
                    chk("din_hold", tx_din, last_din);
                end
                if (mem_rd_en) begin
                    chk("busy_during_rd", busy, 1);
                    chk("rd_expected", exp_addrs.size() != 0, 1);
                    if (exp_addrs.size() != 0) chk("mem_addr", mem_addr, exp_addrs.pop_front());
                    if (chk_first_rd) begin
                        chk("first_rd_latency", cyc - start_cyc, 1);
                        chk_first_rd = 0;
                    end
                end
                if (done) begin
                    chk("done_double", prev_done, 0);
                    chk("done_expected", exp_done > 0, 1);
                    if (exp_done > 0) exp_done--;
                    chk("done_bytes_left", exp_bytes.size(), 0);
                    chk("done_addrs_left", exp_addrs.size(), 0);
                    chk("busy_at_done", busy, 0);
                    if (chk_done_cyc) begin
                        chk("done_latency", cyc - start_cyc, 1);
                        chk_done_cyc = 0;
                    end
                    done_seen++;
                end
                prev_wr   = tx_wr_en;
                prev_done = done;
            end
        end
    end

    task automatic do_start(input int b, input int c, input bit accept, input bit bus_idle);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = ADDR_W'(b);
        count     = (ADDR_W + 1)'(c);
        if (accept) begin
            start_cyc = cyc + 1;
            if (c == 0) begin
                chk_done_cyc = 1;
            end else begin
                for (int i = 0; i < c; i++) begin
                    exp_addrs.push_back(ADDR_W'((b + i) % 16));
                    push_word(mem[(b + i) % 16]);
                end
                chk_first_rd = 1;
                chk_first_wr = bus_idle;
            end
            exp_done++;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int d0;
        d0 = done_seen;
        for (int i = 0; i < max_cyc && done_seen == d0; i++) @(negedge clk);
        chk("done_timeout", done_seen != d0, 1);
    endtask

    initial begin
        string s;
        int g0, rel_cyc;
        logic [7:0] t1 [10];

        for (int i = 0; i < 16; i++) mem[i] = $urandom();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_en", tx_wr_en, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_din", tx_din, 0);
        chk("rst_addr", mem_addr, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single word with separator, literal expectation
        mem[2] = 32'h1234ABCD;
        busy_len = 10;
        got_bytes.delete();
        do_start(2, 1, 1, 1);
        wait_done(2000);
        t1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
        chk("t1_len", got_bytes.size(), 10);
        for (int i = 0; i < 10 && i < got_bytes.size(); i++) chk("t1_lit", got_bytes[i], t1[i]);

        // count = 0
        do_start(5, 0, 1, 1);
        wait_done(10);
        repeat (5) @(negedge clk);

        // Address wrap
        mem[15] = 32'hFFFFFFFF;
        mem[0]  = 32'h00000000;
        got_bytes.delete();
        do_start(15, 2, 1, 1);
        wait_done(4000);
        s = "FFFFFFFF\r\n00000000\r\n";
        chk("wrap_len", got_bytes.size(), 20);
        for (int i = 0; i < 20 && i < got_bytes.size(); i++) chk("wrap_lit", got_bytes[i], s[i]);

        // Long busy before the first character
        mem[3] = 32'h1000_0000;
        hold_busy = 1'b1;
        got_bytes.delete();
        do_start(3, 1, 1, 0);
        repeat (200) @(negedge clk);
        chk("held_no_bytes", got_bytes.size(), 0);
        @(posedge clk); #1;
        hold_busy = 1'b0;
        rel_cyc = cyc + 1;
        repeat (3) @(negedge clk);
        chk("release_bytes", got_bytes.size(), 1);
        chk("release_latency", (last_wr_cyc - rel_cyc) <= 1, 1);
        if (got_bytes.size() != 0) chk("release_char", got_bytes[0], 8'h31);
        wait_done(2000);

        // Start while busy is ignored
        busy_len = 3;
        do_start(4, 2, 1, 1);
        repeat (20) @(negedge clk);
        chk("busy_mid_dump", busy, 1);
        do_start(9, 3, 0, 0);
        wait_done(3000);
        repeat (60) @(negedge clk);
        chk("no_extra_done", exp_done, 0);

        // Reset during WAIT of the 4th character
        busy_len = 10;
        g0 = got_bytes.size();
        do_start(6, 1, 1, 1);
        for (int i = 0; i < 500 && got_bytes.size() < g0 + 4; i++) @(negedge clk);
        chk("reached_4th", got_bytes.size() >= g0 + 4, 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_bytes.delete();
        exp_addrs.delete();
        exp_done = 0;
        chk_first_rd = 0;
        chk_first_wr = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wr_en", tx_wr_en, 0);
        chk("mid_rst_rd_en", mem_rd_en, 0);
        chk("mid_rst_din", tx_din, 0);
        do_start(6, 2, 1, 0);
        wait_done(3000);

        // Randomized dumps
        rand_busy = 1'b1;
        for (int it = 0; it < 8; it++) begin
            int b, c;
            for (int i = 0; i < 16; i++) mem[i] = $urandom();
            b = $urandom_range(0, 15);
            c = (it == 0) ? 16 : int'($urandom_range(1, 5));
            do_start(b, c, 1, 1);
            wait_done(20000);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_hex_dump.md
Name: uart_hex_dump

Overview:
- Read-back path for the UART instruction loader. The loader turns ASCII hex into memory words; this block reads words out of a word memory and sends each one as ASCII hex.
- On a start pulse it reads COUNT consecutive words from BASE through a synchronous read port.
- Each word goes out as 8 uppercase hex characters, MSB nibble first, optionally followed by CR LF.
- It drives the byte-level transmit side of the existing uart (din / wr_en / tx_busy), so a host can verify loaded program or data contents.

Parameters:
- WORD_W, 32, width of the memory word; must be a multiple of 4 (nibbles per word = WORD_W/4).
- ADDR_W, 4, memory address width (16-word memory).
- SEP_EN, 1, 1 = append CR (0x0D) and LF (0x0A) after each word; 0 = no separator.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; captured when start is accepted.
- count  in  ADDR_W+1  number of words to dump, 0..2^ADDR_W; captured when start is accepted.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory read address.
- mem_rdata  in  WORD_W  read data, valid exactly 1 cycle after mem_rd_en.
- tx_din  out  8  byte to the uart transmitter.
- tx_wr_en  out  1  one-cycle write pulse to the uart transmitter.
- tx_busy  in  1  uart transmitter busy.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a dump completes.

Behaviour:
- Reset (rst=1 at a clk edge), from any state including mid-character:
  - state goes to IDLE.
  - tx_wr_en, mem_rd_en, busy and done go to 0; tx_din and mem_addr go to 0.
  - Internal word register, counters and nibble index are cleared.
- Clock and reset: one clock domain; reset is synchronous, active-high, on port rst; clock port is clk.
- States: IDLE, READ, CAPTURE, SEND, GAP, WAIT, NEXT.
- IDLE:
  - start=1 with count!=0: latch base_addr and count, go to READ.
  - start=1 with count=0: pulse done on the next cycle and stay in IDLE; no memory read, no byte sent.
- READ: assert mem_rd_en=1 for one cycle with mem_addr = current address; go to CAPTURE.
- CAPTURE: register mem_rdata into the word register; set nibble index to 0; go to SEND.
- SEND:
  - Wait while tx_busy=1.
  - When tx_busy=0, assert tx_wr_en for exactly one cycle with tx_din = current character; go to GAP.
- GAP: one cycle during which tx_busy is ignored, to cover the uart's one-cycle busy-rise latency; go to WAIT.
- WAIT:
  - Wait while tx_busy=1.
  - When tx_busy=0: if characters remain for this word, advance the character index and go to SEND; otherwise go to NEXT.
- Character sequence per word:
  - Nibbles from [WORD_W-1:WORD_W-4] down to [3:0].
  - Then 0x0D and 0x0A if SEP_EN=1.
- Hex encoding: 0..9 map to 0x30..0x39; A..F map to 0x41..0x46 (uppercase, matching the loader's accepted alphabet).
- NEXT:
  - Decrement the remaining word count and advance the address (address wraps modulo 2^ADDR_W).
  - If remaining = 0: done=1 for one cycle and return to IDLE. Otherwise go to READ.
- Latency, start accepted at cycle 0: mem_rd_en at cycle 1, data captured at cycle 2, first tx_wr_en at cycle 3 at the earliest (if tx_busy=0).
- tx_wr_en never rises while tx_busy=1, and never on two consecutive cycles.
- start while busy=1 is ignored; it is not queued.
- mem_rdata is sampled only in CAPTURE; changes at other times have no effect.
- tx_din holds its value from the wr_en cycle until the next wr_en.
- count = 2^ADDR_W dumps the whole memory once, starting at base.

Decomposition:
- Shared package uart_dump_pkg:
  - state enum (IDLE..NEXT).
  - constants ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_0=8'h30, ASCII_A=8'h41.
  - pure function hex_to_ascii(nibble) returning 8 bits.
- One natural sub-module: hex_char_sel, purely combinational. Inputs are the word register, the character index and SEP_EN; output is the current tx byte.
- The FSM, counters and memory port stay in uart_hex_dump.

Test Plan:
- mem[2]=0x1234ABCD, start with base=2, count=1, SEP_EN=1, tx_busy model high for 10 cycles after each wr_en -> bytes 0x31 0x32 0x33 0x34 0x41 0x42 0x43 0x44 0x0D 0x0A, then exactly one done pulse.
- count=0 -> done pulses the cycle after start; mem_rd_en and tx_wr_en are never asserted.
- base=15, count=2, mem[15]=0xFFFFFFFF, mem[0]=0x00000000 -> mem_addr sequence 15 then 0; output "FFFFFFFF\r\n00000000\r\n".
- Hold tx_busy=1 for 200 cycles before the first char -> no tx_wr_en until tx_busy falls; then 0x31 is sent one cycle later.
- start pulsed again mid-dump with different base and count -> ignored; original dump completes unchanged with one done pulse.
- rst asserted during the WAIT of the 4th char -> next cycle: state IDLE, busy=0, tx_wr_en=0; a fresh start works normally.
